// File: rtl/pe_os_mac_if.sv
// -----------------------------------------------------------------------------
// pe_os_mac_if
// Bundle of every non-clock/non-reset signal of one output-stationary MAC PE.
//   slave  : the PE's own view (operands, control and drain inputs in;
//            forwarded operands, drain data, result and status out).
//   master : the view of whatever drives the PE (controller, neighbours, bench).
// Parameters must match those of the pe_os_mac instance the interface connects.
// -----------------------------------------------------------------------------
interface pe_os_mac_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K_W    = 8
);
    // Operand flow
    logic [DATA_W-1:0] top_in;
    logic              top_valid_in;
    logic [DATA_W-1:0] left_in;
    logic              left_valid_in;
    logic [DATA_W-1:0] bottom_out;
    logic              bottom_valid_out;
    logic [DATA_W-1:0] right_out;
    logic              right_valid_out;
    // Tile control
    logic              clear;
    logic [K_W-1:0]    k_len;
    logic              signed_mode;
    // Drain chain
    logic              drain_shift;
    logic [ACC_W-1:0]  drain_in;
    logic              drain_valid_in;
    logic [ACC_W-1:0]  drain_out;
    logic              drain_valid_out;
    // Result and status
    logic [ACC_W-1:0]  res;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              err;

    modport slave (
        input  top_in, top_valid_in, left_in, left_valid_in,
        input  clear, k_len, signed_mode,
        input  drain_shift, drain_in, drain_valid_in,
        output bottom_out, bottom_valid_out, right_out, right_valid_out,
        output drain_out, drain_valid_out,
        output res, busy, done, ovf, err
    );

    modport master (
        output top_in, top_valid_in, left_in, left_valid_in,
        output clear, k_len, signed_mode,
        output drain_shift, drain_in, drain_valid_in,
        input  bottom_out, bottom_valid_out, right_out, right_valid_out,
        input  drain_out, drain_valid_out,
        input  res, busy, done, ovf, err
    );
endinterface

// File: rtl/pe_os_mac.sv
// -----------------------------------------------------------------------------
// pe_os_mac
// Output-stationary multiply-accumulate processing element for a systolic grid.
// Forwards operands right/down with one cycle of latency, accumulates k_len
// products per tile (signed or unsigned), pulses done on completion and shifts
// the finished result out through a per-column drain chain.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous, active-high
//   bus    : pe_os_mac_if.slave (operands, forwarded operands, tile control,
//            drain chain, res/busy/done/ovf/err)
//
// Build option:
//   PE_SAT_EN defined   -> overflowing adds clamp to the representable limit
//   PE_SAT_EN undefined -> overflowing adds wrap modulo 2^ACC_W
//   ovf is set on overflow in both builds.
// -----------------------------------------------------------------------------
module pe_os_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    pe_os_mac_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2,
        S_PASS  = 2'd3
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [K_W-1:0]     r_cnt;
    logic [K_W-1:0]     r_k_len;
    logic               r_signed;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic               r_err;
    logic [DATA_W-1:0]  r_bottom;
    logic               r_bottom_v;
    logic [DATA_W-1:0]  r_right;
    logic               r_right_v;
    logic [ACC_W-1:0]   r_drain;
    logic               r_drain_v;

    logic                w_fire;
    logic                w_mode;
    logic [2*DATA_W-1:0] w_top_x;
    logic [2*DATA_W-1:0] w_left_x;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W:0]      w_prod_x;
    logic [ACC_W:0]      w_acc_x;
    logic [ACC_W:0]      w_sum;
    logic                w_ovf;
    logic [ACC_W-1:0]    w_acc_next;
    logic [K_W-1:0]      w_cnt_inc;

    // Datapath: one extra bit of headroom makes the exact sum visible so
    // overflow can be judged under the tile's signedness.
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, starting
        // with these defaults, so no latch is inferred.
        w_acc_next = '0;
        w_fire     = bus.top_valid_in & bus.left_valid_in;
        // The clear cycle must use the mode it is latching, not the stale one.
        w_mode     = bus.clear ? bus.signed_mode : r_signed;
        // Sign/zero-extend operands to the product width; the low 2*DATA_W bits
        // of the wide product are then the correct product in either mode.
        w_top_x    = {{DATA_W{w_mode & bus.top_in[DATA_W-1]}}, bus.top_in};
        w_left_x   = {{DATA_W{w_mode & bus.left_in[DATA_W-1]}}, bus.left_in};
        w_prod     = w_top_x * w_left_x;
        w_prod_x   = {{(ACC_W+1-2*DATA_W){w_mode & w_prod[2*DATA_W-1]}}, w_prod};
        w_acc_x    = {r_signed & r_acc[ACC_W-1], r_acc};
        w_sum      = w_acc_x + w_prod_x;
        w_ovf      = r_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
        w_cnt_inc  = r_cnt + K_W'(1);
`ifdef PE_SAT_EN
        if (w_ovf) begin
            if (!r_signed)
                w_acc_next = {ACC_W{1'b1}};
            else if (w_sum[ACC_W])
                w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            else
                w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_acc_next = w_sum[ACC_W-1:0];
        end
`else
        w_acc_next = w_sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_k_len    <= '0;
            r_signed   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_bottom   <= '0;
            r_bottom_v <= 1'b0;
            r_right    <= '0;
            r_right_v  <= 1'b0;
            r_drain    <= '0;
            r_drain_v  <= 1'b0;
        end else begin
            // Operand forwarding is unconditional, bubbles included.
            r_bottom   <= bus.top_in;
            r_bottom_v <= bus.top_valid_in;
            r_right    <= bus.left_in;
            r_right_v  <= bus.left_valid_in;
            r_done     <= 1'b0;

            // Drain uses the pre-clear accumulator when it coincides with clear.
            if (bus.drain_shift) begin
                if (r_state == S_HOLD) begin
                    r_drain   <= r_acc;
                    r_drain_v <= 1'b1;
                end else begin
                    r_drain   <= bus.drain_in;
                    r_drain_v <= bus.drain_valid_in;
                end
            end

            if (bus.clear) begin
                r_k_len  <= bus.k_len;
                r_signed <= bus.signed_mode;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
                if (bus.k_len == '0) begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_HOLD;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else if (w_fire) begin
                    // The product always fits because ACC_W >= 2*DATA_W.
                    r_acc <= w_prod_x[ACC_W-1:0];
                    r_cnt <= K_W'(1);
                    if (bus.k_len == K_W'(1)) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                    end
                end else begin
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_ACCUM;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_ACCUM: begin
                        if (bus.top_valid_in ^ bus.left_valid_in)
                            r_err <= 1'b1;
                        if (w_fire) begin
                            r_acc <= w_acc_next;
                            r_cnt <= w_cnt_inc;
                            if (w_ovf)
                                r_ovf <= 1'b1;
                            if (w_cnt_inc == r_k_len) begin
                                r_state <= S_HOLD;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (bus.drain_shift)
                            r_state <= S_PASS;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.bottom_out       = r_bottom;
    assign bus.bottom_valid_out = r_bottom_v;
    assign bus.right_out        = r_right;
    assign bus.right_valid_out  = r_right_v;
    assign bus.drain_out        = r_drain;
    assign bus.drain_valid_out  = r_drain_v;
    assign bus.res              = r_acc;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.ovf              = r_ovf;
    assign bus.err              = r_err;

endmodule
